seq_det_sweep_ctrl: RTL and testbench

- Controller that exercises one 10101 sequence detector across all four detector modes in turn.
- For each mode it clears the detector, then streams a fixed number of serial bits into it from a captured repeating pattern.
- It counts the detector's `detected` pulses for each mode and holds the four counts for readback.
- It sits between a host/bench and the detector, replacing hand-written per-mode stimulus sequences.

---
 rtl/seq_det_sweep_ctrl.sv | 126 ++++++++++++
 tb/tb_seq_det_sweep_ctrl.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_det_sweep_ctrl.sv
// Drives one 10101 detector through all four modes with an identical serial stream and counts its detections per mode.
// Build option SEQ_SWEEP_LFSR_EN adds a src_sel input and a 16-bit LFSR as an alternative bit source.
module seq_det_sweep_ctrl #(
    parameter int BITS_PER_MODE = 26,
    parameter int PAT_W         = 16,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [PAT_W-1:0] pattern,
`ifdef SEQ_SWEEP_LFSR_EN
    input  logic             src_sel,
`endif
    input  logic             det_detected,
    output logic             det_data,
    output logic [1:0]       det_mode,
    output logic             det_clr,
    output logic             busy,
    output logic             done,
    input  logic [1:0]       rd_sel,
    output logic [CNT_W-1:0] rd_cnt
);

    localparam int PTR_W = $clog2(PAT_W);
    localparam int BIT_W = $clog2(BITS_PER_MODE + 1);

    typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_RUN, S_DRAIN, S_NEXT, S_DONE} state_t;

    state_t           state, next_state;
    logic [PAT_W-1:0] pat_reg;
    logic [PTR_W-1:0] ptr;
    logic [BIT_W-1:0] bit_cnt;
    logic             drain_cnt;
    logic [CNT_W-1:0] counts [4];
    logic             src_bit;
    logic             counting;

    always_comb begin
        // NOTE: next_state gets a default before the case so no path leaves it unassigned and no latch is inferred.
        next_state = state;
        case (state)
            S_IDLE:  if (start) next_state = S_CLEAR;
            S_CLEAR: next_state = S_RUN;
            S_RUN:   if (bit_cnt == BIT_W'(BITS_PER_MODE)) next_state = S_DRAIN;
            S_DRAIN: if (drain_cnt) next_state = S_NEXT;
            S_NEXT:  next_state = (det_mode == 2'b11) ? S_DONE : S_CLEAR;
            S_DONE:  next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

`ifdef SEQ_SWEEP_LFSR_EN
    logic        src_sel_reg;
    logic [15:0] lfsr, lfsr_cur, seed;

    // In CLEAR the seed itself supplies the first bit, so every mode restarts the same sequence.
    always_comb begin
        seed     = (pat_reg[15:0] == 16'h0000) ? 16'hACE1 : pat_reg[15:0];
        lfsr_cur = (state == S_CLEAR) ? seed : lfsr;
        src_bit  = src_sel_reg ? lfsr_cur[0] : pat_reg[ptr];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            src_sel_reg <= 1'b0;
            lfsr        <= '0;
        end else begin
            if (state == S_IDLE && start) src_sel_reg <= src_sel;
            if (next_state == S_RUN)
                lfsr <= {lfsr_cur[0] ^ lfsr_cur[2] ^ lfsr_cur[3] ^ lfsr_cur[5], lfsr_cur[15:1]};
        end
    end
`else
    assign src_bit = pat_reg[ptr];
`endif

    assign counting = (state == S_RUN) || (state == S_DRAIN);
    assign rd_cnt   = counts[rd_sel];

    // Outputs are registered from next_state so they line up with the state they describe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            det_data  <= 1'b0;
            det_mode  <= 2'b00;
            det_clr   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pat_reg   <= '0;
            ptr       <= '0;
            bit_cnt   <= '0;
            drain_cnt <= 1'b0;
            // NOTE: the count array is only four registers, so it is cleared by reset like any other state.
            counts    <= '{default: '0};
        end else begin
            // NOTE: all sequential state uses non-blocking assignment so every register sees pre-edge values.
            state     <= next_state;
            det_clr   <= (next_state == S_CLEAR);
            busy      <= (next_state != S_IDLE);
            done      <= (next_state == S_DONE);
            det_data  <= (next_state == S_RUN) ? src_bit : 1'b0;
            drain_cnt <= (state == S_DRAIN);

            if (next_state == S_CLEAR) begin
                ptr     <= '0;
                bit_cnt <= '0;
            end
            if (next_state == S_RUN) begin
                ptr     <= (ptr == PTR_W'(PAT_W - 1)) ? '0 : ptr + PTR_W'(1);
                bit_cnt <= bit_cnt + BIT_W'(1);
            end

            if (state == S_IDLE && start) begin
                pat_reg  <= pattern;
                det_mode <= 2'b00;
                counts   <= '{default: '0};
            end
            if (state == S_NEXT && det_mode != 2'b11) det_mode <= det_mode + 2'd1;

            if (counting && det_detected && counts[det_mode] != {CNT_W{1'b1}})
                counts[det_mode] <= counts[det_mode] + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_seq_det_sweep_ctrl.sv
// Bench for seq_det_sweep_ctrl: two controllers (CNT_W=8 and CNT_W=3), each driving a behavioural 10101 detector,
// checked against expected counts from a table and from a stream/occurrence model of the same rules.
module tb_seq_det_sweep_ctrl;

    localparam int BPM       = 26;
    localparam int SWEEP_LEN = 4 * (1 + BPM + 2 + 1) + 1;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [15:0] pattern = '0;
    logic [1:0]  rd_sel = '0;
`ifdef SEQ_SWEEP_LFSR_EN
    logic        src_sel = 1'b0;
`endif

    logic       det_data_a, det_clr_a, busy_a, done_a, det_detected_a;
    logic [1:0] det_mode_a;
    logic [7:0] rd_cnt_a;
    logic       det_data_b, det_clr_b, busy_b, done_b, det_detected_b;
    logic [1:0] det_mode_b;
    logic [2:0] rd_cnt_b;

    always #5 clk = ~clk;

    seq_det_sweep_ctrl #(.BITS_PER_MODE(BPM), .PAT_W(16), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .pattern(pattern),
`ifdef SEQ_SWEEP_LFSR_EN
        .src_sel(src_sel),
`endif
        .det_detected(det_detected_a), .det_data(det_data_a), .det_mode(det_mode_a),
        .det_clr(det_clr_a), .busy(busy_a), .done(done_a), .rd_sel(rd_sel), .rd_cnt(rd_cnt_a)
    );

    seq_det_sweep_ctrl #(.BITS_PER_MODE(BPM), .PAT_W(16), .CNT_W(3)) dut3 (
        .clk(clk), .rst(rst), .start(start), .pattern(pattern),
`ifdef SEQ_SWEEP_LFSR_EN
        .src_sel(src_sel),
`endif
        .det_detected(det_detected_b), .det_data(det_data_b), .det_mode(det_mode_b),
        .det_clr(det_clr_b), .busy(busy_b), .done(done_b), .rd_sel(rd_sel), .rd_cnt(rd_cnt_b)
    );

    // Stand-in detector: a 5-bit window of bits seen since the last clear (or last match when non-overlapping).
    function automatic logic window_hit(input logic [4:0] h, input int v, input logic d);
        return (v >= 4) && ({h[3:0], d} == 5'b10101);
    endfunction

    logic [4:0] h_a, h_b;
    int         v_a, v_b;
    logic       mf_a, mf_b;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            h_a <= '0; v_a <= 0; mf_a <= 1'b0;
            h_b <= '0; v_b <= 0; mf_b <= 1'b0;
        end else begin
            if (det_clr_a) begin
                h_a <= '0; v_a <= 0; mf_a <= 1'b0;
            end else begin
                mf_a <= window_hit(h_a, v_a, det_data_a);
                if (det_mode_a[0] && window_hit(h_a, v_a, det_data_a)) begin
                    h_a <= '0; v_a <= 0;
                end else begin
                    h_a <= {h_a[3:0], det_data_a}; v_a <= (v_a < 5) ? v_a + 1 : 5;
                end
            end
            if (det_clr_b) begin
                h_b <= '0; v_b <= 0; mf_b <= 1'b0;
            end else begin
                mf_b <= window_hit(h_b, v_b, det_data_b);
                if (det_mode_b[0] && window_hit(h_b, v_b, det_data_b)) begin
                    h_b <= '0; v_b <= 0;
                end else begin
                    h_b <= {h_b[3:0], det_data_b}; v_b <= (v_b < 5) ? v_b + 1 : 5;
                end
            end
        end
    end

    assign det_detected_a = det_mode_a[1] ? (!det_clr_a && window_hit(h_a, v_a, det_data_a)) : mf_a;
    assign det_detected_b = det_mode_b[1] ? (!det_clr_b && window_hit(h_b, v_b, det_data_b)) : mf_b;

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference model: the bit stream each mode should receive, and occurrence counts of 10101 in it.
    logic exp_bits [BPM];

    task automatic build_stream(input logic [15:0] pat, input logic sel);
        logic [15:0] s;
        s = (pat == 16'h0000) ? 16'hACE1 : pat;
        for (int i = 0; i < BPM; i++) begin
            if (sel) begin
                exp_bits[i] = s[0];
                s = {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
            end else begin
                exp_bits[i] = pat[i % 16];
            end
        end
    endtask

    function automatic int ref_count(input bit nonovl);
        int c    = 0;
        int last = -1;
        for (int i = 4; i < BPM; i++) begin
            if ((!nonovl || i - 4 > last) && exp_bits[i-4] == 1'b1 && exp_bits[i-3] == 1'b0 &&
                exp_bits[i-2] == 1'b1 && exp_bits[i-1] == 1'b0 && exp_bits[i] == 1'b1) begin
                c++;
                last = i;
            end
        end
        return c;
    endfunction

    typedef struct {
        logic [15:0]     pat;
        logic            sel;
        logic            use_model;
        logic [3:0][7:0] exp8;
        logic [3:0][7:0] exp3;
    } vec_t;

    vec_t vecs[$];

    task automatic run_sweep(input vec_t v, input int disturb_cyc, input string tag);
        int   cyc, len, dones, done_at, clrs, pos, bit_bad, mode_bad, ctl_bad;
        logic e;
        build_stream(v.pat, v.sel);
        @(negedge clk);
        pattern = v.pat;
`ifdef SEQ_SWEEP_LFSR_EN
        src_sel = v.sel;
`endif
        start = 1'b1;
        @(negedge clk);
        cyc = 1; len = 0; dones = 0; done_at = 0; clrs = 0;
        pos = BPM + 2; bit_bad = 0; mode_bad = 0; ctl_bad = 0;
        while (cyc <= 300 && busy_a) begin
            len = cyc;
            if (done_a) begin dones++; done_at = cyc; end
            if (busy_b !== busy_a || done_b !== done_a || det_clr_b !== det_clr_a || det_mode_b !== det_mode_a)
                ctl_bad++;
            if (det_clr_a) begin
                if (int'(det_mode_a) != clrs) mode_bad++;
                clrs++;
                pos = 0;
            end else if (pos < BPM + 2) begin
                e = (pos < BPM) ? exp_bits[pos] : 1'b0;
                if (det_data_a !== e) bit_bad++;
                if (det_data_b !== e) bit_bad++;
                pos++;
            end
            start = (cyc == disturb_cyc);
            if (cyc == disturb_cyc) pattern = 16'h0000;
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        check($sformatf("%s.sweep_len", tag), len, SWEEP_LEN);
        check($sformatf("%s.done_pulses", tag), dones, 1);
        check($sformatf("%s.done_on_last_busy", tag), done_at, len);
        check($sformatf("%s.clr_cycles", tag), clrs, 4);
        check($sformatf("%s.mode_order_errs", tag), mode_bad, 0);
        check($sformatf("%s.stream_errs", tag), bit_bad, 0);
        check($sformatf("%s.ctl_diff_cnt3", tag), ctl_bad, 0);
        for (int m = 0; m < 4; m++) begin
            rd_sel = 2'(m);
            #1;
            check($sformatf("%s.cnt8[%0d]", tag, m), int'(rd_cnt_a), int'(v.exp8[m]));
            check($sformatf("%s.cnt3[%0d]", tag, m), int'(rd_cnt_b), int'(v.exp3[m]));
        end
    endtask

    initial begin
        int c;
        vecs.push_back('{pat: 16'h5555, sel: 1'b0, use_model: 1'b0,
                         exp8: {8'd4, 8'd11, 8'd4, 8'd11}, exp3: {8'd4, 8'd7, 8'd4, 8'd7}});
        vecs.push_back('{pat: 16'h0000, sel: 1'b0, use_model: 1'b0, exp8: '0, exp3: '0});
        vecs.push_back('{pat: 16'hFFFF, sel: 1'b0, use_model: 1'b0, exp8: '0, exp3: '0});
        for (int i = 0; i < 4; i++)
            vecs.push_back('{pat: 16'($urandom), sel: 1'b0, use_model: 1'b1, exp8: '0, exp3: '0});
`ifdef SEQ_SWEEP_LFSR_EN
        vecs.push_back('{pat: 16'h0000, sel: 1'b1, use_model: 1'b1, exp8: '0, exp3: '0});
        vecs.push_back('{pat: 16'($urandom), sel: 1'b1, use_model: 1'b1, exp8: '0, exp3: '0});
`endif
        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].use_model) begin
                build_stream(vecs[i].pat, vecs[i].sel);
                for (int m = 0; m < 4; m++) begin
                    c = ref_count(m[0]);
                    vecs[i].exp8[m] = 8'(c);
                    vecs[i].exp3[m] = 8'((c > 7) ? 7 : c);
                end
            end
        end

        repeat (3) @(negedge clk);
        check("reset.busy", busy_a, 0);
        check("reset.done", done_a, 0);
        check("reset.det_clr", det_clr_a, 0);
        check("reset.det_data", det_data_a, 0);
        check("reset.det_mode", det_mode_a, 0);
        for (int m = 0; m < 4; m++) begin
            rd_sel = 2'(m);
            #1;
            check($sformatf("reset.cnt8[%0d]", m), rd_cnt_a, 0);
        end
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < vecs.size(); i++)
            run_sweep(vecs[i], 0, $sformatf("vec%0d", i));

        // Re-start request and pattern change during mode 1 must not disturb the sweep.
        run_sweep(vecs[0], 40, "disturb");

        // Asynchronous reset in the middle of mode 2's RUN phase.
        @(negedge clk);
        pattern = 16'h5555;
`ifdef SEQ_SWEEP_LFSR_EN
        src_sel = 1'b0;
`endif
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (69) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("midrst.busy", busy_a, 0);
        check("midrst.done", done_a, 0);
        check("midrst.det_clr", det_clr_a, 0);
        check("midrst.det_data", det_data_a, 0);
        check("midrst.det_mode", det_mode_a, 0);
        for (int m = 0; m < 4; m++) begin
            rd_sel = 2'(m);
            #1;
            check($sformatf("midrst.cnt8[%0d]", m), rd_cnt_a, 0);
        end
        @(negedge clk);
        rst = 1'b1;
        run_sweep(vecs[0], 0, "after_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
